etapa_fetch: RTL
================

Name: etapa_fetch

Overview:
- Instruction-fetch stage of the MIPS32 pipeline.
- Holds the program counter and drives it to the PC+4 adder (sumador4) and to instruction memory.
- Selects the next PC from four sources: the adder result, branch target, jump target or exception vector.
- Handles a multi-cycle instruction-memory handshake and loads the IF/ID pipeline register consumed by decode.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_0180, PC loaded on flush (exception entry).
- NOP_INSTR, 32'h0000_0000, value driven on if_id_instr when the slot is invalid.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc  out  32  current PC; feeds sumador4 PC input and imem_addr.
- newpc  in  32  PC+4 from sumador4 (combinational from pc).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory completes the request this cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  32  branch target address.
- jump  in  1  redirect to jump_target.
- jump_target  in  32  jump target address.
- flush  in  1  exception: redirect to EXC_VECTOR.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a live instruction.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and has top priority.
- Reset values: pc=RESET_VECTOR, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, pending target=0, state=ARRANQUE.
- FSM states:
  - ARRANQUE: imem_req=0; next cycle goes to FETCH unconditionally.
  - FETCH: imem_req=1.
  - DESCARTE: imem_req=1; the outstanding fetch is still completing and its data is dropped.
- Memory contract:
  - imem_addr stays stable while imem_req=1 and imem_ready=0.
  - Memory holds imem_rdata/imem_ready while req stays high at the same address.
- Redirect: redir = flush | jump | branch_taken. Target priority is flush > jump > branch. Target bits [1:0] are forced to 2'b00.
- accept = (state==FETCH) & imem_ready & !stall & !redir.
- On accept:
  - if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=newpc.
  - One-instruction throughput per cycle when imem_ready is held high.
- Stall without redir:
  - pc, IF/ID and state hold. imem_req stays high.
  - A ready memory response is not consumed and is re-sampled after the stall.
- Redir in FETCH:
  - if_id_valid<=0 and if_id_instr<=NOP_INSTR, regardless of stall.
  - If imem_ready=1: data is dropped, pc<=target, state stays FETCH.
  - If imem_ready=0: the target is saved in the pending register, pc holds (address stable), state goes to DESCARTE.
- In DESCARTE:
  - A further redir overwrites the pending target (same priority rules).
  - On imem_ready: data is dropped, pc<=pending, state goes to FETCH.
  - if_id_valid stays 0.
- No branch delay slot: the sequential instruction after a redirect is squashed.
- Wrap-around: newpc is used as given; 0xFFFF_FFFC -> 0x0000_0000 is legal, with no flag.
- Redirect and stall in the same cycle: the redirect wins (hazard unit qualifies its redirects).
- rst asserted mid-DESCARTE or mid-stall: all state returns to reset values next edge and the outstanding fetch is abandoned.

Decomposition:
- Shared package mips_pkg holds:
  - FSM encodings (ARRANQUE=2'd0, FETCH=2'd1, DESCARTE=2'd2).
  - Default RESET_VECTOR, EXC_VECTOR and NOP_INSTR.
  - A 2-bit redirect-source enum.
- One sub-module, registro_if_id: IF/ID register with load, kill and hold inputs.
- sumador4 remains an external sibling instance wired pc->PC, newpc->newpc.

Test Plan:
- Reset then imem_ready=1 constantly, instructions I0..I3:
  - ARRANQUE for 1 cycle.
  - if_id_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, valid=1.
- imem_ready low 3 cycles at pc=0x8:
  - imem_addr stays 0x8, if_id_valid holds its previous value, no pc change.
  - The accept follows ready.
- stall=1 for 2 cycles with ready=1:
  - pc and IF/ID frozen.
  - The instruction at pc is accepted on the cycle after stall drops.
- branch_taken=1, branch_target=0x103 while ready=0:
  - Enters DESCARTE. The returning word is dropped.
  - Next fetch address is 0x100, if_id_valid=0 meanwhile.
- flush and jump (target 0x40) in the same cycle with ready=1:
  - pc<=0x180, IF/ID killed.
- pc forced to 0xFFFF_FFFC, ready=1:
  - Next pc 0x0000_0000.
  - rst asserted during DESCARTE: pc=0x0 next cycle, state ARRANQUE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline: fetch FSM encodings,
// default vectors and the redirect-source encoding.
package mips_pkg;

    localparam logic [1:0] ARRANQUE = 2'd0;
    localparam logic [1:0] FETCH    = 2'd1;
    localparam logic [1:0] DESCARTE = 2'd2;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
    localparam logic [31:0] DEF_NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JUMP   = 2'd2,
        SRC_FLUSH  = 2'd3
    } redir_src_t;

    // Flush beats jump beats branch.
    function automatic redir_src_t redir_src(input logic flush, input logic jump,
                                             input logic branch_taken);
        if (flush)             return SRC_FLUSH;
        else if (jump)         return SRC_JUMP;
        else if (branch_taken) return SRC_BRANCH;
        else                   return SRC_NONE;
    endfunction

endpackage

// File: rtl/etapa_fetch_registro_if_id.sv
// IF/ID pipeline register: kill inserts a bubble, load captures a fetched
// instruction unless hold is asserted.
module registro_if_id
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_kill,
    input  logic        i_hold,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;

    // Kill wins over hold: a redirect squashes the slot even while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= 32'h0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_kill) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load && !i_hold) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/etapa_fetch.sv
// MIPS32 instruction-fetch stage: PC register, next-PC selection,
// multi-cycle imem handshake and IF/ID loading.
module etapa_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
    parameter logic [31:0] NOP_INSTR    = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] newpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        flush,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [1:0]  dbg_state
);

    // Handshake: imem_req=1 presents imem_addr (=pc); the word is taken on a
    // cycle where imem_ready=1. pc never moves while a request is unanswered.

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending;

    redir_src_t  w_src;
    logic        w_redir;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_kill;

    assign w_src   = redir_src(flush, jump, branch_taken);
    assign w_redir = (w_src != SRC_NONE);

    always_comb begin
        w_target = 32'h0;
        case (w_src)
            SRC_FLUSH:  w_target = EXC_VECTOR;
            SRC_JUMP:   w_target = jump_target;
            SRC_BRANCH: w_target = branch_target;
            default:    w_target = 32'h0;
        endcase
        w_target[1:0] = 2'b00;
    end

    assign w_accept = (r_state == FETCH) && imem_ready && !stall && !w_redir;
    assign w_kill   = w_redir || (r_state == DESCARTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARRANQUE;
            r_pc      <= RESET_VECTOR;
            r_pending <= 32'h0;
        end else begin
            case (r_state)
                ARRANQUE: begin
                    // No request is outstanding yet, so a redirect applies at once.
                    if (w_redir) r_pc <= w_target;
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (w_redir) begin
                        if (imem_ready) begin
                            r_pc <= w_target;
                        end else begin
                            r_pending <= w_target;
                            r_state   <= DESCARTE;
                        end
                    end else if (w_accept) begin
                        r_pc <= newpc;
                    end
                end
                DESCARTE: begin
                    if (w_redir) r_pending <= w_target;
                    if (imem_ready) begin
                        r_pc    <= w_redir ? w_target : r_pending;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= ARRANQUE;
            endcase
        end
    end

    registro_if_id #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_kill (w_kill),
        .i_hold (stall),
        .i_pc   (r_pc),
        .i_instr(imem_rdata),
        .o_pc   (if_id_pc),
        .o_instr(if_id_instr),
        .o_valid(if_id_valid)
    );

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign imem_req  = (r_state != ARRANQUE);
    assign dbg_state = r_state;

endmodule
